// File: rtl/fpnew_pkg.sv
// Minimal slice of the FPnew package: the floating-point format enumeration and
// its bit-width helper, as referenced by the RedMulE datapath parameters.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 16;
        endcase
    endfunction

endpackage

// File: rtl/redmule_pkg.sv
// RedMulE shared definitions used by the Z result-collection stage.
package redmule_pkg;

    // Width of the job-length and pushed-vector counters.
    localparam int unsigned ZCollCntW = 16;

    typedef enum logic [1:0] {
        ZC_IDLE  = 2'd0,
        ZC_RUN   = 2'd1,
        ZC_DRAIN = 2'd2,
        ZC_DONE  = 2'd3
    } z_coll_state_e;

endpackage

// File: rtl/redmule_z_fifo.sv
// Fall-through FIFO holding Z vectors plus a per-entry last flag; the head is
// read combinationally from registered storage.
module redmule_z_fifo #(
    parameter  int unsigned DataW = 64,
    parameter  int unsigned Depth = 4,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned CntW  = AddrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [DataW-1:0] data_i,
    input  logic             last_i,
    input  logic             pop_i,
    output logic [DataW-1:0] data_o,
    output logic             last_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [DataW-1:0] mem_q [Depth];
    logic [Depth-1:0] last_q;
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;

    logic do_push, do_pop;

    assign do_push = push_i && !clear_i;
    assign do_pop  = pop_i  && !clear_i;

    // NOTE: storage is reset because the head is visible on the output even
    // when no entry is valid, and it must read as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            last_q <= '0;
        end else if (do_push) begin
            mem_q[wptr_q]  <= data_i;
            last_q[wptr_q] <= last_i;
        end
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign last_o  = last_q[rptr_q];
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/redmule_z_collector.sv
// Z result collector: buffers row-array output vectors, counts them against
// the programmed job length and streams them out with a last flag.
module redmule_z_collector
    import redmule_pkg::*;
#(
    parameter  fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::FP16,
    parameter  int unsigned           Width    = 4,
    parameter  int unsigned           Depth    = 4,
    localparam int unsigned           BITW     = fpnew_pkg::fp_width(FpFormat)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            start_i,
    input  logic [ZCollCntW-1:0]            total_i,
    input  logic [Width-1:0][BITW-1:0]      z_i,
    input  logic                            z_valid_i,
    output logic                            stall_o,
    output logic [Width-1:0][BITW-1:0]      z_o,
    output logic                            z_valid_o,
    output logic                            z_last_o,
    input  logic                            z_ready_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int unsigned DataW = Width * BITW;
    localparam int unsigned CntW  = $clog2(Depth) + 1;

    z_coll_state_e        state_q;
    logic [ZCollCntW-1:0] total_q;
    logic [ZCollCntW-1:0] pushed_q;
    logic                 err_q;

    logic             fifo_full, fifo_empty, head_last;
    logic [CntW-1:0]  fifo_cnt;
    logic [DataW-1:0] fifo_data;

    logic pop, push, drop, last_in;

    assign pop     = !fifo_empty && z_ready_i;
    // A full FIFO still accepts a vector when the head leaves in the same cycle.
    assign push    = z_valid_i && (state_q == ZC_RUN) && (!fifo_full || pop);
    assign drop    = z_valid_i && !push;
    assign last_in = ((pushed_q + 1'b1) == total_q);

    redmule_z_fifo #(
        .DataW (DataW),
        .Depth (Depth)
    ) i_z_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .data_i  (z_i),
        .last_i  (last_in),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .last_o  (head_last),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ZC_IDLE;
            total_q  <= '0;
            pushed_q <= '0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            state_q  <= ZC_IDLE;
            pushed_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (drop) begin
                err_q <= 1'b1;
            end
            if (push) begin
                pushed_q <= pushed_q + 1'b1;
            end
            case (state_q)
                ZC_IDLE: begin
                    if (start_i) begin
                        total_q  <= total_i;
                        pushed_q <= '0;
                        state_q  <= (total_i == '0) ? ZC_DONE : ZC_RUN;
                    end
                end
                ZC_RUN: begin
                    if (push && last_in) begin
                        state_q <= ZC_DRAIN;
                    end
                end
                ZC_DRAIN: begin
                    // The flagged entry is the newest one, so the FIFO is empty after it leaves.
                    if (pop && head_last) begin
                        state_q <= ZC_DONE;
                    end
                end
                ZC_DONE: state_q <= ZC_IDLE;
                default: state_q <= ZC_IDLE;
            endcase
        end
    end

    // One slot of slack covers the array's one-cycle enable response.
    assign stall_o   = (fifo_cnt >= CntW'(Depth - 1));
    assign z_o       = fifo_data;
    assign z_valid_o = !fifo_empty;
    assign z_last_o  = head_last;
    assign busy_o    = (state_q != ZC_IDLE);
    assign done_o    = (state_q == ZC_DONE);
    assign err_o     = err_q;

endmodule

// File: tb/tb_redmule_z_collector.sv
// Self-checking bench for redmule_z_collector: a queue-based job model checked
// every cycle, plus hand-computed expectations at key points of each scenario.
module tb_redmule_z_collector;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int BW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 clear_i = 1'b0;
    logic                 start_i = 1'b0;
    logic [15:0]          total_i = '0;
    logic [W-1:0][BW-1:0] z_i = '0;
    logic                 z_valid_i = 1'b0;
    logic                 z_ready_i = 1'b0;
    logic                 stall_o, z_valid_o, z_last_o, busy_o, done_o, err_o;
    logic [W-1:0][BW-1:0] z_o;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    redmule_z_collector #(
        .FpFormat (fpnew_pkg::FP16),
        .Width    (W),
        .Depth    (D)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   (clear_i),
        .start_i   (start_i),
        .total_i   (total_i),
        .z_i       (z_i),
        .z_valid_i (z_valid_i),
        .stall_o   (stall_o),
        .z_o       (z_o),
        .z_valid_o (z_valid_o),
        .z_last_o  (z_last_o),
        .z_ready_i (z_ready_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] vec(input int k);
        logic [63:0] r;
        for (int i = 0; i < W; i++) begin
            r[i*BW +: BW] = 16'(16'h3C00 + k * 16 + i);
        end
        return r;
    endfunction

    // Job model: a queue of outstanding entries, a count of vectors still
    // expected in the job, and flags for "job open", "done pulse" and "error".
    typedef struct {
        logic [63:0] data;
        logic        last;
    } ent_t;

    ent_t mq[$];
    bit   m_in_job, m_done, m_err;
    int   m_remaining;

    always @(posedge clk or negedge rst_n) begin : model
        bit   idle, do_pop, do_push, next_done;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_in_job = 0; m_done = 0; m_err = 0; m_remaining = 0;
        end else if (clear_i) begin
            mq.delete();
            m_in_job = 0; m_done = 0; m_err = 0; m_remaining = 0;
        end else begin
            idle      = !m_in_job && !m_done;
            do_pop    = (mq.size() != 0) && z_ready_i;
            do_push   = z_valid_i && m_in_job && (m_remaining > 0) && ((mq.size() < D) || do_pop);
            next_done = 0;
            if (z_valid_i && !do_push) m_err = 1;
            if (do_pop) begin
                e = mq.pop_front();
                if (e.last) begin
                    next_done = 1;
                    m_in_job  = 0;
                end
            end
            if (do_push) begin
                e.data = z_i;
                e.last = (m_remaining == 1);
                mq.push_back(e);
                m_remaining--;
            end
            if (start_i && idle) begin
                if (total_i == 0) next_done = 1;
                else begin
                    m_in_job    = 1;
                    m_remaining = int'(total_i);
                end
            end
            m_done = next_done;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_z_valid", z_valid_o, mq.size() != 0);
            if (mq.size() != 0) begin
                check("m_z_data", z_o, mq[0].data);
                check("m_z_last", z_last_o, mq[0].last);
            end
            check("m_stall", stall_o, mq.size() >= D - 1);
            check("m_busy", busy_o, m_in_job || m_done);
            check("m_done", done_o, m_done);
            check("m_err", err_o, m_err);
        end
    end

    task automatic cyc(input logic v, input logic [63:0] d, input logic rdy);
        @(negedge clk);
        z_valid_i = v; z_i = d; z_ready_i = rdy; start_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic start_job(input int t, input logic rdy);
        @(negedge clk);
        start_i = 1'b1; total_i = 16'(t); z_valid_i = 1'b0; z_ready_i = rdy; clear_i = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk);
        clear_i = 1'b1; start_i = 1'b0; z_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_z_o", z_o, 64'h0);
        check("rst_valid", z_valid_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // total=3, ready high: three beats in order, last on the third.
        start_job(3, 1'b1);
        cyc(1'b1, 64'h3C00_3C01_3C02_3C03, 1'b1);
        cyc(1'b1, 64'h4000_4001_4002_4003, 1'b1);
        check("t1_head0", z_o, 64'h3C00_3C01_3C02_3C03);
        check("t1_last0", z_last_o, 1'b0);
        cyc(1'b1, 64'h4200_4201_4202_4203, 1'b1);
        check("t1_head1", z_o, 64'h4000_4001_4002_4003);
        cyc(1'b0, '0, 1'b1);
        check("t1_head2", z_o, 64'h4200_4201_4202_4203);
        check("t1_last2", z_last_o, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("t1_done", done_o, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("t1_done_off", done_o, 1'b0);
        check("t1_busy_off", busy_o, 1'b0);

        // total=6, ready low: stall at three entries, fifth vector dropped.
        start_job(6, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, vec(k), 1'b0);
            check("t2_stall", stall_o, k >= 3);
        end
        cyc(1'b0, '0, 1'b0);
        check("t2_err", err_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("t2_drain", z_o, vec(k));
            check("t2_nolast", z_last_o, 1'b0);
        end
        cyc(1'b1, vec(5), 1'b1);
        check("t2_empty", z_valid_o, 1'b0);
        cyc(1'b1, vec(6), 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("t2_final_last", z_last_o, 1'b1);
        idle(3);
        clr();

        // Full FIFO with a simultaneous push and pop.
        start_job(8, 1'b0);
        for (int k = 10; k < 14; k++) cyc(1'b1, vec(k), 1'b0);
        cyc(1'b1, vec(14), 1'b1);
        check("t3_full_valid", z_valid_o, 1'b1);
        cyc(1'b0, '0, 1'b0);
        check("t3_stall", stall_o, 1'b1);
        check("t3_head", z_o, vec(11));
        check("t3_err", err_o, 1'b0);
        for (int k = 15; k < 18; k++) cyc(1'b1, vec(k), 1'b1);
        idle(8);

        // Zero-length job.
        start_job(0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("t4_done", done_o, 1'b1);
        check("t4_novalid", z_valid_o, 1'b0);
        cyc(1'b0, '0, 1'b1);
        check("t4_done_off", done_o, 1'b0);

        // Clear in DRAIN with two entries queued.
        start_job(2, 1'b0);
        cyc(1'b1, vec(20), 1'b0);
        cyc(1'b1, vec(21), 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("t5_queued", z_valid_o, 1'b1);
        clear_i = 1'b1;
        cyc(1'b0, '0, 1'b0);
        check("t5_valid", z_valid_o, 1'b0);
        check("t5_busy", busy_o, 1'b0);
        check("t5_done", done_o, 1'b0);
        idle(2);

        // Push in IDLE, then a start issued during RUN.
        cyc(1'b1, vec(30), 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("t6_err", err_o, 1'b1);
        check("t6_empty", z_valid_o, 1'b0);
        clr();
        start_job(3, 1'b1);
        cyc(1'b1, vec(31), 1'b1);
        cyc(1'b1, vec(32), 1'b1);
        start_i = 1'b1; total_i = 16'd1;
        check("t6_last31", z_last_o, 1'b0);
        cyc(1'b1, vec(33), 1'b1);
        check("t6_last32", z_last_o, 1'b0);
        cyc(1'b0, '0, 1'b1);
        check("t6_head33", z_o, vec(33));
        check("t6_last33", z_last_o, 1'b1);
        idle(3);

        // Asynchronous reset in the middle of a job.
        start_job(5, 1'b0);
        cyc(1'b1, vec(40), 1'b0);
        cyc(1'b1, vec(41), 1'b0);
        #2 rst_n = 1'b0;
        cyc(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        check("t7_z_o", z_o, 64'h0);
        check("t7_busy", busy_o, 1'b0);
        idle(2);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
